// File: rtl/ab_arb_pkg.sv
// Shared encodings for the A/B round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// State encoding keeps gnt_a = state[0] and gnt_b = state[1], so both grants
// can never be high together.
package ab_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_A = 2'b01,
    ARB_GNT_B = 2'b10
  } arb_state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/ab_hold_counter.sv
// Saturating count of consecutive cycles the current owner has held its grant.
// Latency: clr/en act at the next edge; at_limit is decoded from the register.
// Backpressure: none; the counter stops at MAX_HOLD-1 until cleared.
//
// Ports:
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   clr        restart the count at 0 next edge (takes priority over en)
//   en         advance the count by one (ignored once saturated)
//   at_limit   count has reached MAX_HOLD-1
module ab_hold_counter #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_limit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ab_rr_arbiter.sv
// Two-requester round-robin arbiter; grant held until the owner drops its request.
// Latency: request sampled at edge N, grant visible right after edge N.
// Backpressure: requests are not queued; a request dropped before being granted is lost.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   req_a, req_b    level requests, held high while the resource is needed
//   gnt_a, gnt_b    registered grants, mutually exclusive
//   busy            gnt_a | gnt_b
//   owner           0 = A, 1 = B while busy, else 0
//   preempt         one-cycle pulse alongside the first cycle of a forced handoff
//
// Optional feature macro ARB_TIMEOUT_EN: limits a grant to MAX_HOLD consecutive
// cycles when the other side is waiting. Without it preempt is tied 0 and a
// grant lasts as long as its owner requests.
module ab_rr_arbiter
  import ab_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic busy,
  output logic owner,
  output logic preempt
);

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("ab_rr_arbiter: MAX_HOLD must be >= 2");
  end

  arb_state_t state_q, state_d;
  logic       last_q, last_d;   // side that most recently gave up the resource

`ifdef ARB_TIMEOUT_EN
  logic preempt_q, preempt_d;
  logic at_limit;
  logic hold_clr;
  logic hold_en;

  // Count restarts on every grant change, so a forced handoff gives the new
  // owner a full MAX_HOLD window.
  assign hold_clr = (state_d != state_q) || (state_q == ARB_IDLE);
  assign hold_en  = (state_q != ARB_IDLE);

  ab_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (hold_clr),
    .en       (hold_en),
    .at_limit (at_limit)
  );
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    preempt_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (req_a && (!req_b || last_q == OWN_B)) begin
          state_d = ARB_GNT_A;
        end else if (req_b) begin
          state_d = ARB_GNT_B;
        end
      end
      ARB_GNT_A: begin
        if (!req_a) begin
          // Zero-bubble handoff when B is already waiting.
          state_d = req_b ? ARB_GNT_B : ARB_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (at_limit && req_b) begin
          state_d   = ARB_GNT_B;
          preempt_d = 1'b1;
        end
`endif
      end
      ARB_GNT_B: begin
        if (!req_b) begin
          state_d = req_a ? ARB_GNT_A : ARB_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (at_limit && req_a) begin
          state_d   = ARB_GNT_A;
          preempt_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (state_q == ARB_GNT_A && state_d != ARB_GNT_A) begin
      last_d = OWN_A;
    end else if (state_q == ARB_GNT_B && state_d != ARB_GNT_B) begin
      last_d = OWN_B;
    end
  end

  // last resets to B so that A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= OWN_B;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  // Moore decode straight from the state register.
  assign gnt_a = (state_q == ARB_GNT_A);
  assign gnt_b = (state_q == ARB_GNT_B);
  assign busy  = gnt_a | gnt_b;
  assign owner = gnt_b ? OWN_B : OWN_A;

endmodule
